// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch / program-counter stage
//
// Purpose:
//   Holds the 10-bit PC and reads 9-bit instructions from a synchronous ROM.
//   Each instruction is presented to decode for at least one cycle. When the
//   stage leaves DECODE it computes the next PC from the branch code, the
//   4-bit offset and the register-file target p_target.
//   Optional macro FETCH_PERF_EN adds the cycle_count/instr_count counters.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin execution at RESET_PC (IDLE/HALTED only)
//   stall                 freeze the stage while in DECODE
//   branch, instr_o       branch code and offset from decode
//   br_zero, p_target     zero flag and absolute target from the register file
//   imem_addr, imem_data  ROM address and ROM data (one-cycle read latency)
//   instr, instr_valid    instruction presented to decode
//   pc                    address of instr
//   done                  HALT_OP has executed
//   cycle_count           (FETCH_PERF_EN) cycles spent in FETCH/DECODE
//   instr_count           (FETCH_PERF_EN) instructions retired
module fetch_unit #(
   parameter logic [9:0] RESET_PC = 10'h000,
   parameter logic [8:0] HALT_OP  = 9'h1FF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stall,
   input  logic [2:0]  branch,
   input  logic [3:0]  instr_o,
   input  logic        br_zero,
   input  logic [9:0]  p_target,
   output logic [9:0]  imem_addr,
   input  logic [8:0]  imem_data,
   output logic [8:0]  instr,
   output logic        instr_valid,
   output logic [9:0]  pc,
   output logic        done
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0] cycle_count,
   output logic [15:0] instr_count
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      DECODE = 2'd2,
      HALTED = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [9:0]  pc_d;
   logic [8:0]  instr_d;
   logic        valid_d;
   logic        done_d;
   logic [9:0]  pc_inc;
   logic [9:0]  next_pc;

   // Branch target computation; all arithmetic wraps modulo 1024.
   always_comb begin
      pc_inc  = pc + 10'd1;
      next_pc = pc_inc;
      case (branch)
         3'd4:    next_pc = pc + {6'd0, instr_o} + 10'd1;
         3'd5:    next_pc = pc - {6'd0, instr_o} - 10'd1;
         3'd6:    next_pc = br_zero  ? p_target : pc_inc;
         3'd7:    next_pc = !br_zero ? p_target : pc_inc;
         default: next_pc = pc_inc;
      endcase
   end

   // Next-state and output logic.
   // The ROM registers its address, so the address of the next instruction
   // is driven in the cycle that enters FETCH. The ROM output is then ready
   // during FETCH, and FETCH stays one cycle long. While in FETCH,
   // imem_addr equals pc.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc;
      instr_d   = instr;
      valid_d   = instr_valid;
      done_d    = done;
      imem_addr = pc;
      case (state_q)
         IDLE: begin
            if (start) begin
               pc_d      = RESET_PC;
               imem_addr = RESET_PC;
               state_d   = FETCH;
            end
         end
         FETCH: begin
            instr_d = imem_data;
            valid_d = 1'b1;
            state_d = DECODE;
         end
         DECODE: begin
            if (!stall) begin
               valid_d = 1'b0;
               if (instr == HALT_OP) begin
                  done_d  = 1'b1;
                  state_d = HALTED;
               end else begin
                  pc_d      = next_pc;
                  imem_addr = next_pc;
                  state_d   = FETCH;
               end
            end
         end
         HALTED: begin
            if (start) begin
               done_d    = 1'b0;
               pc_d      = RESET_PC;
               imem_addr = RESET_PC;
               state_d   = FETCH;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pc          <= RESET_PC;
         instr       <= 9'd0;
         instr_valid <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc          <= pc_d;
         instr       <= instr_d;
         instr_valid <= valid_d;
         done        <= done_d;
      end
   end

`ifdef FETCH_PERF_EN
   logic launch;
   logic active;
   logic retire;

   assign launch = start && ((state_q == IDLE) || (state_q == HALTED));
   assign active = (state_q == FETCH) || (state_q == DECODE);
   assign retire = (state_q == DECODE) && !stall;

   // Both counters saturate rather than wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_count <= 16'd0;
         instr_count <= 16'd0;
      end else if (launch) begin
         cycle_count <= 16'd0;
         instr_count <= 16'd0;
      end else begin
         if (active && (cycle_count != 16'hFFFF))
            cycle_count <= cycle_count + 16'd1;
         if (retire && (instr_count != 16'hFFFF))
            instr_count <= instr_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        stall;
   logic [2:0]  branch;
   logic [3:0]  instr_o;
   logic        br_zero;
   logic [9:0]  p_target;
   logic [9:0]  imem_addr;
   logic [8:0]  imem_data;
   logic [8:0]  instr;
   logic        instr_valid;
   logic [9:0]  pc;
   logic        done;
`ifdef FETCH_PERF_EN
   logic [15:0] cycle_count;
   logic [15:0] instr_count;
`endif

   int errors = 0;
   int checks = 0;

   logic [8:0] rom [1024];

   typedef struct {
      logic [9:0] pc;
      logic [8:0] instr;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   always @(posedge clk) imem_data <= rom[imem_addr];

   fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .stall       (stall),
      .branch      (branch),
      .instr_o     (instr_o),
      .br_zero     (br_zero),
      .p_target    (p_target),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc          (pc),
      .done        (done)
`ifdef FETCH_PERF_EN
      ,
      .cycle_count (cycle_count),
      .instr_count (instr_count)
`endif
   );

   task automatic init_rom();
      for (int i = 0; i < 1024; i++) rom[i] = 9'(i) ^ 9'h055;
   endtask

   task automatic push(input logic [9:0] a);
      exp_t e;
      e.pc    = a;
      e.instr = rom[a];
      sb.push_back(e);
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      start    = 1'b0;
      stall    = 1'b0;
      branch   = 3'd0;
      instr_o  = 4'd0;
      br_zero  = 1'b0;
      p_target = 10'd0;
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Consume one decoded instruction: check it against the scoreboard, hold
   // it stalled for nstall cycles with junk branch inputs, then release it
   // with the given branch inputs.
   task automatic step(input logic [2:0] br, input logic [3:0] off,
                       input logic z, input logic [9:0] tgt, input int nstall);
      int   w;
      exp_t e;
      w = 0;
      while (instr_valid !== 1'b1 && w < 8) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (instr_valid !== 1'b1) begin
         errors++;
         $display("FAIL decode_timeout: instr_valid=%b required 1", instr_valid);
         return;
      end
      checks++;
      if (w != 1) begin
         errors++;
         $display("FAIL fetch_latency: waited %0d cycles required 1", w);
      end
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_empty: decoded pc=%h with nothing expected", pc);
         return;
      end
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc) begin
         errors++;
         $display("FAIL decode_pc: got %h required %h", pc, e.pc);
      end
      checks++;
      if (instr !== e.instr) begin
         errors++;
         $display("FAIL decode_instr: got %h required %h (pc %h)", instr, e.instr, e.pc);
      end
      for (int k = 0; k < nstall; k++) begin
         stall    = 1'b1;
         branch   = 3'($urandom_range(4, 7));
         instr_o  = 4'($urandom);
         br_zero  = 1'($urandom);
         p_target = 10'($urandom);
         @(negedge clk);
         checks++;
         if (instr_valid !== 1'b1 || pc !== e.pc || instr !== e.instr) begin
            errors++;
            $display("FAIL stall_hold: valid=%b pc=%h instr=%h required 1 %h %h",
                     instr_valid, pc, instr, e.pc, e.instr);
         end
      end
      stall    = 1'b0;
      branch   = br;
      instr_o  = off;
      br_zero  = z;
      p_target = tgt;
      @(posedge clk);
      @(negedge clk);
      branch   = 3'd0;
      instr_o  = 4'd0;
      checks++;
      if (instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL valid_drop: instr_valid=%b required 0", instr_valid);
      end
   endtask

   task automatic test_reset();
      init_rom();
      do_reset();
      checks++;
      if (pc !== 10'h000) begin errors++; $display("FAIL reset_pc: got %h required 000", pc); end
      checks++;
      if (imem_addr !== 10'h000) begin errors++; $display("FAIL reset_addr: got %h required 000", imem_addr); end
      checks++;
      if (instr !== 9'h000) begin errors++; $display("FAIL reset_instr: got %h required 000", instr); end
      checks++;
      if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", instr_valid); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
      repeat (3) @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0 || pc !== 10'h000) begin
         errors++;
         $display("FAIL idle_hold: valid=%b pc=%h required 0 000", instr_valid, pc);
      end
   endtask

   task automatic check_halted(input logic [9:0] hpc);
      checks++;
      if (done !== 1'b1 || pc !== hpc || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL halt_state: done=%b pc=%h valid=%b required 1 %h 0",
                  done, pc, instr_valid, hpc);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (done !== 1'b1 || pc !== hpc || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL halt_hold: done=%b pc=%h valid=%b required 1 %h 0",
                  done, pc, instr_valid, hpc);
      end
   endtask

   task automatic test_sequential();
      init_rom();
      rom[0] = 9'h001;
      rom[1] = 9'h002;
      rom[2] = 9'h1FF;
      do_reset();
      for (int pass = 0; pass < 2; pass++) begin
         push(10'h000);
         push(10'h001);
         push(10'h002);
         pulse_start();
         checks++;
         if (done !== 1'b0) begin errors++; $display("FAIL start_clears_done: got %b required 0", done); end
         step(3'd0, 4'd0, 1'b0, 10'd0, 0);
         step(3'd1, 4'd7, 1'b1, 10'h3AA, 0);
         step(3'd0, 4'd0, 1'b0, 10'd0, 0);
         check_halted(10'h002);
`ifdef FETCH_PERF_EN
         checks++;
         if (instr_count !== 16'd3 || cycle_count !== 16'd6) begin
            errors++;
            $display("FAIL perf_counts: instr=%0d cycle=%0d required 3 6", instr_count, cycle_count);
         end
`endif
      end
   endtask

   task automatic test_branches();
      init_rom();
      rom[10'h300] = 9'h1FF;
      do_reset();
      push(10'h000); push(10'h010); push(10'h014); push(10'h010);
      push(10'h020); push(10'h155); push(10'h020); push(10'h021);
      push(10'h020); push(10'h155); push(10'h020); push(10'h021);
      push(10'h3FF); push(10'h000); push(10'h3FF); push(10'h300);
      pulse_start();
      step(3'd4, 4'hF, 1'b0, 10'h000, 0);  // 000 -> 010
      step(3'd4, 4'h3, 1'b1, 10'h155, 0);  // 010 -> 014
      step(3'd5, 4'h3, 1'b1, 10'h155, 0);  // 014 -> 010
      step(3'd6, 4'h5, 1'b1, 10'h020, 0);  // 010 -> 020
      step(3'd6, 4'h0, 1'b1, 10'h155, 0);  // bizr taken
      step(3'd7, 4'h0, 1'b0, 10'h020, 0);  // bnzr taken 155 -> 020
      step(3'd6, 4'h0, 1'b0, 10'h155, 0);  // bizr not taken -> 021
      step(3'd7, 4'h0, 1'b0, 10'h020, 0);  // 021 -> 020
      step(3'd7, 4'h0, 1'b0, 10'h155, 0);  // bnzr taken -> 155
      step(3'd6, 4'h0, 1'b1, 10'h020, 0);  // 155 -> 020
      step(3'd7, 4'h0, 1'b1, 10'h155, 0);  // bnzr not taken -> 021
      step(3'd6, 4'h0, 1'b1, 10'h3FF, 0);  // 021 -> 3FF
      step(3'd3, 4'hF, 1'b1, 10'h155, 0);  // no branch, wraps -> 000
      step(3'd5, 4'h0, 1'b0, 10'h155, 0);  // jmpb wraps -> 3FF
      step(3'd6, 4'h0, 1'b1, 10'h300, 0);  // 3FF -> 300 (halt)
      step(3'd0, 4'h0, 1'b0, 10'h000, 0);
      check_halted(10'h300);
   endtask

   task automatic test_stall();
      init_rom();
      rom[10'h300] = 9'h1FF;
      do_reset();
      push(10'h000);
      push(10'h300);
      pulse_start();
      stall = 1'b1;  // raised during FETCH, must not delay the ROM read
      step(3'd6, 4'h0, 1'b1, 10'h300, 3);
      step(3'd0, 4'h0, 1'b0, 10'h000, 2);
      check_halted(10'h300);
   endtask

   task automatic test_reset_mid();
      int w;
      init_rom();
      do_reset();
      push(10'h000);
      pulse_start();
      step(3'd4, 4'hF, 1'b0, 10'h000, 0);  // 000 -> 010
      w = 0;
      while (instr_valid !== 1'b1 && w < 8) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (instr_valid !== 1'b1 || pc !== 10'h010) begin
         errors++;
         $display("FAIL pre_reset_decode: valid=%b pc=%h required 1 010", instr_valid, pc);
      end
      branch  = 3'd4;
      instr_o = 4'h7;
      rst_n   = 1'b0;
      #1;
      checks++;
      if (instr_valid !== 1'b0 || pc !== 10'h000 || imem_addr !== 10'h000 || done !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: valid=%b pc=%h addr=%h done=%b required 0 000 000 0",
                  instr_valid, pc, imem_addr, done);
      end
`ifdef FETCH_PERF_EN
      checks++;
      if (cycle_count !== 16'd0 || instr_count !== 16'd0) begin
         errors++;
         $display("FAIL perf_reset: cycle=%0d instr=%0d required 0 0", cycle_count, instr_count);
      end
`endif
      @(negedge clk);
      rst_n  = 1'b1;
      branch = 3'd0;
      repeat (3) @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0 || pc !== 10'h000) begin
         errors++;
         $display("FAIL post_reset_idle: valid=%b pc=%h required 0 000", instr_valid, pc);
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branches();
      test_stall();
      test_reset_mid();
      test_sequential();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
